andgate_vec_checker: RTL and testbench
======================================

Name: andgate_vec_checker

Overview:
Self-checking stimulus stage wrapped around the 2-input AND gate. Upstream, it drives the gate's a/b inputs through the full truth table (00, 01, 10, 11). Downstream, it samples the gate's y output on each vector and compares it against the expected a&b. It counts mismatches and reports pass/fail. Used as synthesizable on-chip BIST and as a reusable bench driver.

Parameters:
HOLD_CYCLES, 10, cycles each vector is held on a/b; legal range >= 1
PASSES, 1, number of full 4-vector sweeps per run; legal range >= 1
ERR_W, 8, width of error counter

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  begin a run; sampled in IDLE or DONE
y  input  1  output of gate under test (combinational from a,b)
a  output  1  gate input a
b  output  1  gate input b
busy  output  1  high while sweeping
done  output  1  high in DONE until next start or reset
pass  output  1  done && err_count==0
err_count  output  ERR_W  mismatch count, saturating
vec_idx  output  2  current vector index; {a,b} == vec_idx

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset value of every output is 0: a, b, busy, done, pass, err_count, vec_idx. Internal hold_cnt and pass_cnt are 0. State is IDLE.
- rst asserted mid-run aborts at the next edge with no partial result retained.
- FSM states:
  - IDLE: start=1 -> DRIVE. Clears err_count, vec_idx=0, hold_cnt=0, pass_cnt=0.
  - DRIVE: a=vec_idx[1], b=vec_idx[0], busy=1.
    - hold_cnt increments each cycle.
    - On the cycle where hold_cnt==HOLD_CYCLES-1, y is compared to a&b. A mismatch increments err_count, saturating at 2^ERR_W-1. hold_cnt then returns to 0 and vec_idx increments, wrapping 3->0.
    - When vec_idx wraps, pass_cnt increments.
    - On the last compare of the last pass, go to DONE.
  - DONE: done=1, busy=0, a=b=0, err_count held. start=1 -> same clear/transition as IDLE (restart).
- start in DRIVE is ignored.
- start is level-sampled: held high continuously, it restarts a run one cycle after each DONE entry.
- Latency: if start is sampled at edge k, a/b=00 from edge k. done rises at edge k+4*HOLD_CYCLES*PASSES. Total cycles busy = 4*HOLD_CYCLES*PASSES.
- y is sampled only at the final hold cycle of each vector, so a glitching y earlier in the hold window is not an error.
- With HOLD_CYCLES=1, each vector lasts exactly one cycle and is compared on that cycle.
- a/b/vec_idx change only on a vector boundary, never mid-hold.

Optional Feature:
ANDGATE_FAIL_CAPTURE_EN:
- When defined, adds two output ports:
  - first_fail_vld (1): reset 0. Set on the first mismatch of a run.
  - first_fail_vec (2): reset 0. The vec_idx of that first mismatch; frozen until the next start or rst.
- Both ports clear on start.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Ideal AND gate, HOLD_CYCLES=10, PASSES=1, start pulse at edge k:
  - done rises at edge k+40; pass=1, err_count=0.
  - a/b sequence is 00,01,10,11, 10 cycles each.
- y stuck-at-0, PASSES=2:
  - err_count=2 (vector 11 each pass), pass=0.
  - With ANDGATE_FAIL_CAPTURE_EN: first_fail_vld=1, first_fail_vec=3.
- y stuck-at-1, ERR_W=2, PASSES=2:
  - Raw mismatches are 6; err_count saturates at 3; pass=0.
  - With ANDGATE_FAIL_CAPTURE_EN: first_fail_vec=0.
- y glitches to 1 during hold cycles 0..8 of vector 01 but is correct on cycle 9, HOLD_CYCLES=10:
  - err_count=0, pass=1.
- rst asserted 15 cycles into a run:
  - All outputs are 0 the next cycle; state IDLE.
  - A new start then completes normally with pass=1.
- start re-asserted during DRIVE is ignored, so done timing is unchanged.
- start asserted in DONE clears err_count and done the next cycle, and busy=1.

Source files
------------

// File: rtl/andgate_vec_checker.sv
// ---------------------------------------------------------------------------
// andgate_vec_checker
//
// Stimulus/checker stage wrapped around a 2-input AND gate under test.
// Drives {a,b} through 00,01,10,11, holds each vector HOLD_CYCLES cycles,
// samples y on the final hold cycle of each vector and compares it with a&b.
// Mismatches are counted in a saturating counter. The sweep repeats PASSES
// times, then the block parks in DONE and reports pass/fail.
//
// Parameters:
//   HOLD_CYCLES  cycles each vector is held (>= 1)
//   PASSES       full 4-vector sweeps per run (>= 1)
//   ERR_W        width of the mismatch counter
//
// Optional build macro:
//   ANDGATE_FAIL_CAPTURE_EN  adds first_fail_vld / first_fail_vec outputs
//                            recording the vector of the first mismatch.
//
// Ports:
//   clk            clock, all logic on rising edge
//   rst            synchronous reset, active-high
//   start          begin a run (level-sampled in IDLE or DONE, ignored in DRIVE)
//   y              output of the gate under test
//   a, b           gate inputs, {a,b} == vec_idx while busy, 0 otherwise
//   busy           high while sweeping
//   done           high in DONE until the next start or reset
//   pass           done && err_count == 0
//   err_count      saturating mismatch count of the current/last run
//   vec_idx        current vector index
//   state_o        debug view of the FSM state (0 IDLE, 1 DRIVE, 2 DONE)
//   first_fail_vld first mismatch of the run has been seen (optional)
//   first_fail_vec vec_idx of that first mismatch (optional)
//
// Handshake: start is a level, not a valid/ready pair. Every rising edge at
// which start is high while the FSM is in IDLE or DONE launches a run; there
// is no back-pressure and no acknowledge other than busy going high.
// ---------------------------------------------------------------------------
module andgate_vec_checker #(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned PASSES      = 1,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             y,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       vec_idx,
    output logic [1:0]       state_o
`ifdef ANDGATE_FAIL_CAPTURE_EN
   ,output logic             first_fail_vld
   ,output logic [1:0]       first_fail_vec
`endif
);

    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [PC_W-1:0] PASS_LAST = PC_W'(PASSES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [HC_W-1:0]   hold_q, hold_d;
    logic [PC_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [1:0]        vec_q, vec_d;
    logic [ERR_W-1:0]  err_q, err_d;

    logic launch;        // start accepted this cycle
    logic compare_now;   // final hold cycle of the current vector
    logic mismatch;      // y disagrees with a&b on the compare cycle
    logic last_compare;  // last vector of the last pass

`ifdef ANDGATE_FAIL_CAPTURE_EN
    logic       ff_vld_q, ff_vld_d;
    logic [1:0] ff_vec_q, ff_vec_d;
`endif

    assign launch       = start && (state_q == S_IDLE || state_q == S_DONE);
    assign compare_now  = (state_q == S_DRIVE) && (hold_q == HOLD_LAST);
    assign mismatch     = compare_now && (y != (a & b));
    assign last_compare = compare_now && (vec_q == 2'd3) && (pass_cnt_q == PASS_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_DRIVE;
            S_DRIVE: if (last_compare) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_DRIVE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        a         = 1'b0;
        b         = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        if (state_q == S_DRIVE) begin
            a    = vec_q[1];
            b    = vec_q[0];
            busy = 1'b1;
        end
        if (state_q == S_DONE) begin
            done = 1'b1;
        end
        pass      = done && (err_q == '0);
        err_count = err_q;
        vec_idx   = vec_q;
        state_o   = state_q;
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        hold_d     = hold_q;
        pass_cnt_d = pass_cnt_q;
        vec_d      = vec_q;
        err_d      = err_q;
`ifdef ANDGATE_FAIL_CAPTURE_EN
        ff_vld_d   = ff_vld_q;
        ff_vec_d   = ff_vec_q;
`endif
        if (launch) begin
            hold_d     = '0;
            pass_cnt_d = '0;
            vec_d      = 2'd0;
            err_d      = '0;
`ifdef ANDGATE_FAIL_CAPTURE_EN
            ff_vld_d   = 1'b0;
            ff_vec_d   = 2'd0;
`endif
        end else if (state_q == S_DRIVE) begin
            if (compare_now) begin
                // Vector boundary: a/b/vec_idx only ever move here.
                hold_d = '0;
                vec_d  = vec_q + 2'd1;
                if (vec_q == 2'd3) begin
                    pass_cnt_d = pass_cnt_q + 1'b1;
                end
                if (mismatch && (err_q != '1)) begin
                    err_d = err_q + 1'b1;
                end
`ifdef ANDGATE_FAIL_CAPTURE_EN
                if (mismatch && !ff_vld_q) begin
                    ff_vld_d = 1'b1;
                    ff_vec_d = vec_q;
                end
`endif
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q     <= '0;
            pass_cnt_q <= '0;
            vec_q      <= 2'd0;
            err_q      <= '0;
        end else begin
            hold_q     <= hold_d;
            pass_cnt_q <= pass_cnt_d;
            vec_q      <= vec_d;
            err_q      <= err_d;
        end
    end

`ifdef ANDGATE_FAIL_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ff_vld_q <= 1'b0;
            ff_vec_q <= 2'd0;
        end else begin
            ff_vld_q <= ff_vld_d;
            ff_vec_q <= ff_vec_d;
        end
    end

    assign first_fail_vld = ff_vld_q;
    assign first_fail_vec = ff_vec_q;
`endif

endmodule

// File: tb/tb_andgate_vec_checker.sv
// ---------------------------------------------------------------------------
// tb_andgate_vec_checker
//
// Bench for andgate_vec_checker. The gate under test is modelled here; its
// y output can be ideal, stuck, glitching inside the hold window, or flipped
// on randomly chosen vectors with random noise before each compare cycle.
// The expected a/b sequence, error count and first-fail vector are derived
// from cycle position arithmetic (slot = t / HOLD, hold position = t % HOLD).
// ---------------------------------------------------------------------------
module tb_andgate_vec_checker;

    localparam int H  = 5;
    localparam int P  = 2;
    localparam int EW = 2;
    localparam int N  = 4 * H * P;
    localparam int SAT = (1 << EW) - 1;

    localparam int M_IDEAL  = 0;
    localparam int M_STUCK0 = 1;
    localparam int M_STUCK1 = 2;
    localparam int M_GLITCH = 3;
    localparam int M_RANDOM = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic          y = 1'b0;
    logic          a, b, busy, done, pass;
    logic [EW-1:0] err_count;
    logic [1:0]    vec_idx;
    logic [1:0]    state_o;
`ifdef ANDGATE_FAIL_CAPTURE_EN
    logic          first_fail_vld;
    logic [1:0]    first_fail_vec;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    bit flip [0:4*P-1];

    andgate_vec_checker #(
        .HOLD_CYCLES(H),
        .PASSES     (P),
        .ERR_W      (EW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .y        (y),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .vec_idx  (vec_idx),
        .state_o  (state_o)
`ifdef ANDGATE_FAIL_CAPTURE_EN
       ,.first_fail_vld(first_fail_vld)
       ,.first_fail_vec(first_fail_vec)
`endif
    );

    // ---------------- driver / model: one full run ----------------
    // Called #1 after an edge with the DUT in IDLE or DONE. Returns #1 after
    // the edge at which done should rise. poke_start raises start mid-run;
    // hold_start keeps start high for the whole run.
    task automatic run_sweep(input string name, input int mode,
                             input bit poke_start, input bit hold_start);
        int         raw;
        int         first;
        bit         ffv;
        int         slot;
        int         sv;
        int         hp;
        logic       ea, eb;
        logic [EW-1:0] exp_err;
        raw = 0; first = 0; ffv = 1'b0;
        for (int s = 0; s < 4 * P; s++) flip[s] = 1'($urandom_range(0, 1));
        start = 1'b1;
        @(posedge clk); #1;
        for (int t = 0; t < N; t++) begin
            slot = t / H;
            sv   = slot % 4;
            hp   = t % H;
            ea   = 1'(sv >> 1);
            eb   = 1'(sv & 1);
            start = hold_start || (poke_start && t >= H + 1 && t <= H + 3);
            // gate under test
            case (mode)
                M_STUCK0: y = 1'b0;
                M_STUCK1: y = 1'b1;
                M_GLITCH: y = ({a, b} == 2'b01 && hp != H - 1) ? 1'b1 : (a & b);
                M_RANDOM: y = (hp != H - 1) ? 1'($urandom_range(0, 1)) : ((a & b) ^ flip[slot]);
                default:  y = a & b;
            endcase
            n_checks++;
            if (a !== ea || b !== eb) $display("FAIL %s ab t=%0d: got %b%b want %b%b", name, t, a, b, ea, eb);
            else n_pass++;
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) $display("FAIL %s busy/done t=%0d: got %b/%b want 1/0", name, t, busy, done);
            else n_pass++;
            n_checks++;
            if (vec_idx !== 2'(sv)) $display("FAIL %s vec_idx t=%0d: got %0d want %0d", name, t, vec_idx, sv);
            else n_pass++;
            if (t == 0) begin
                n_checks++;
                if (err_count !== '0) $display("FAIL %s err_cleared: got %0d want 0", name, err_count);
                else n_pass++;
`ifdef ANDGATE_FAIL_CAPTURE_EN
                n_checks++;
                if (first_fail_vld !== 1'b0) $display("FAIL %s ff_cleared: got %b want 0", name, first_fail_vld);
                else n_pass++;
`endif
            end
            // reference: only the last hold cycle of each vector is judged
            if (hp == H - 1 && y !== (ea & eb)) begin
                raw++;
                if (!ffv) begin ffv = 1'b1; first = sv; end
            end
            @(posedge clk); #1;
        end
        exp_err = EW'((raw > SAT) ? SAT : raw);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) $display("FAIL %s end done/busy: got %b/%b want 1/0", name, done, busy);
        else n_pass++;
        n_checks++;
        if (a !== 1'b0 || b !== 1'b0) $display("FAIL %s end ab: got %b%b want 00", name, a, b);
        else n_pass++;
        n_checks++;
        if (err_count !== exp_err) $display("FAIL %s err_count: got %0d want %0d (raw %0d)", name, err_count, exp_err, raw);
        else n_pass++;
        n_checks++;
        if (pass !== (raw == 0)) $display("FAIL %s pass: got %b want %b", name, pass, raw == 0);
        else n_pass++;
`ifdef ANDGATE_FAIL_CAPTURE_EN
        n_checks++;
        if (first_fail_vld !== ffv) $display("FAIL %s first_fail_vld: got %b want %b", name, first_fail_vld, ffv);
        else n_pass++;
        if (ffv) begin
            n_checks++;
            if (first_fail_vec !== 2'(first)) $display("FAIL %s first_fail_vec: got %0d want %0d", name, first_fail_vec, first);
            else n_pass++;
        end
`endif
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({a, b, busy, done, pass} !== 5'b0) $display("FAIL reset flags: got %b want 00000", {a, b, busy, done, pass});
        else n_pass++;
        n_checks++;
        if (err_count !== '0 || vec_idx !== 2'd0 || state_o !== 2'd0)
            $display("FAIL reset regs: got err=%0d vec=%0d st=%0d want 0/0/0", err_count, vec_idx, state_o);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ideal();           run_sweep("ideal",   M_IDEAL,  1'b0, 1'b0); endtask
    task automatic test_stuck0();          run_sweep("stuck0",  M_STUCK0, 1'b0, 1'b0); endtask
    task automatic test_restart_from_done(); run_sweep("restart", M_IDEAL, 1'b0, 1'b0); endtask
    task automatic test_stuck1();          run_sweep("stuck1",  M_STUCK1, 1'b0, 1'b0); endtask
    task automatic test_glitch();          run_sweep("glitch",  M_GLITCH, 1'b0, 1'b0); endtask
    task automatic test_start_in_drive();  run_sweep("poke",    M_IDEAL,  1'b1, 1'b0); endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) run_sweep("random", M_RANDOM, 1'b0, 1'b0);
    endtask

    task automatic test_rst_mid_run();
        start = 1'b1;
        y = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({a, b, busy, done, pass} !== 5'b0) $display("FAIL rst_mid flags: got %b want 00000", {a, b, busy, done, pass});
        else n_pass++;
        n_checks++;
        if (err_count !== '0 || vec_idx !== 2'd0 || state_o !== 2'd0)
            $display("FAIL rst_mid regs: got err=%0d vec=%0d st=%0d want 0/0/0", err_count, vec_idx, state_o);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        run_sweep("after_rst", M_IDEAL, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_sweep("b2b", M_STUCK0, 1'b0, 1'b1);
        // start still high: the DONE state lasts exactly one cycle
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || err_count !== '0)
            $display("FAIL b2b restart: got busy=%b done=%b err=%0d want 1/0/0", busy, done, err_count);
        else n_pass++;
        n_checks++;
        if (a !== 1'b0 || b !== 1'b0) $display("FAIL b2b restart ab: got %b%b want 00", a, b);
        else n_pass++;
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_stuck0();
        test_restart_from_done();
        test_stuck1();
        test_glitch();
        test_start_in_drive();
        test_random();
        test_rst_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
